// File: rtl/gbc_video_memory_target_if.sv
// rtl/gbc_video_memory_target_if.sv - Wishbone-style bus bundle for the GBC video memory target
interface gbc_video_memory_target_if;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [13:0] wb_adr;
  logic [7:0]  wb_dat_i;
  logic [1:0]  wb_tga;
  logic        wb_tgc;
  logic [7:0]  wb_dat_o;
  logic        wb_ack;
  logic        wb_stall;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, wb_tga, wb_tgc,
    input  wb_dat_o, wb_ack, wb_stall
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_i, wb_tga, wb_tgc,
    output wb_dat_o, wb_ack, wb_stall
  );
endinterface

// File: rtl/gbc_video_memory_target.sv
// rtl/gbc_video_memory_target.sv - GBC VRAM/OAM/register target with OAM DMA copy; optional GBC_VRAM_LOCKOUT_EN
module gbc_video_memory_target #(
  parameter int VRAM_BANKS = 2,
  parameter int OAM_BYTES  = 160
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [1:0]                ppu_mode,
  gbc_video_memory_target_if.slave  bus
);

  localparam int          VRAM_DEPTH = VRAM_BANKS * 8192;
  localparam logic [13:0] VRAM_MASK  = (VRAM_BANKS > 1) ? 14'h3FFF : 14'h1FFF;
  localparam logic [8:0]  OAM_LIMIT  = 9'(OAM_BYTES);

  typedef enum logic [1:0] {IDLE, RESP, DMA_COPY} state_t;

  state_t      state, state_d;
  logic        first_q;
  logic [7:0]  dat_q, dat_d;
  logic [7:0]  copy_byte;
  logic [7:0]  copy_idx;
  logic        copy_ok;

  logic [7:0]  vram [VRAM_DEPTH];
  logic [7:0]  oam  [OAM_BYTES];
  logic [7:0]  regs [64];

  logic        accept;
  logic        is_copy;
  logic        lock;
  logic [13:0] vram_idx;
  logic [7:0]  oam_idx;
  logic        oam_ok;
  logic [5:0]  reg_idx;
  logic [7:0]  resp;
  logic        vram_we;
  logic        oam_we;
  logic        reg_we;
  logic        copy_commit;

  assign bus.wb_stall = reset | first_q | (state == DMA_COPY);
  assign bus.wb_ack   = (state == RESP) & bus.wb_cyc;
  assign bus.wb_dat_o = dat_q;

  assign accept   = bus.wb_cyc & bus.wb_stb & ~bus.wb_stall;
  assign is_copy  = (bus.wb_tga == 2'b00) & bus.wb_tgc;
  assign vram_idx = bus.wb_adr & VRAM_MASK;
  assign oam_idx  = bus.wb_adr[7:0];
  assign oam_ok   = {1'b0, oam_idx} < OAM_LIMIT;
  assign reg_idx  = bus.wb_adr[5:0];

`ifdef GBC_VRAM_LOCKOUT_EN
  // CPU is locked out of VRAM while drawing and out of OAM during scan/draw; DMA never is
  assign lock = ~bus.wb_tgc &
                (((bus.wb_tga == 2'b00) & (ppu_mode == 2'd3)) |
                 ((bus.wb_tga == 2'b01) & ppu_mode[1]));
`else
  logic unused_mode;
  assign unused_mode = ^ppu_mode;
  assign lock        = 1'b0;
`endif

  // An OAM DMA cycle to OAM space is always a write; the copy path only reads VRAM here
  assign vram_we     = accept & (bus.wb_tga == 2'b00) & ~bus.wb_tgc & bus.wb_we & ~lock;
  assign oam_we      = accept & (bus.wb_tga == 2'b01) & oam_ok & (bus.wb_tgc | (bus.wb_we & ~lock));
  assign reg_we      = accept & (bus.wb_tga == 2'b10) & bus.wb_we;
  assign copy_commit = (state == DMA_COPY) & ~reset & copy_ok;

  // Response byte for the request presented this cycle
  always_comb begin
    resp = 8'hFF;
    case (bus.wb_tga)
      2'b00: begin
        if (bus.wb_tgc)     resp = 8'hA0;
        else if (lock)      resp = 8'hFF;
        else if (bus.wb_we) resp = bus.wb_dat_i;
        else                resp = vram[vram_idx];
      end
      2'b01: begin
        if (bus.wb_tgc)     resp = 8'hD0;
        else if (lock)      resp = 8'hFF;
        else if (!oam_ok)   resp = 8'h00;
        else if (bus.wb_we) resp = bus.wb_dat_i;
        else                resp = oam[oam_idx];
      end
      2'b10:   resp = bus.wb_we ? bus.wb_dat_i : regs[reg_idx];
      default: resp = 8'hFF;
    endcase
  end

  // Next state and next response data
  always_comb begin
    state_d = state;
    dat_d   = dat_q;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_d = is_copy ? DMA_COPY : RESP;
          if (!is_copy) dat_d = resp;
        end else begin
          state_d = IDLE;
        end
      end
      DMA_COPY: begin
        // A dropped cycle still lets the copy land but swallows the ack
        if (bus.wb_cyc) begin
          state_d = RESP;
          dat_d   = 8'hA0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, response data and post-reset stall flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dat_q   <= 8'h00;
      first_q <= 1'b1;
    end else begin
      state   <= state_d;
      dat_q   <= dat_d;
      first_q <= 1'b0;
    end
  end

  // Capture the VRAM byte and OAM target on the accept cycle of a copy
  always_ff @(posedge clk) begin
    if (accept && is_copy) begin
      copy_byte <= vram[vram_idx];
      copy_idx  <= oam_idx;
      copy_ok   <= oam_ok;
    end
  end

  // Register file, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
    end else if (reg_we) begin
      regs[reg_idx] <= bus.wb_dat_i;
    end
  end

  // VRAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (vram_we) vram[vram_idx] <= bus.wb_dat_i;
  end

  // OAM write port: copy commit and bus writes never coincide because the copy stalls the bus
  always_ff @(posedge clk) begin
    if (copy_commit)  oam[copy_idx] <= copy_byte;
    else if (oam_we)  oam[oam_idx]  <= bus.wb_dat_i;
  end

endmodule

// File: tb/tb_gbc_video_memory_target.sv
// tb/tb_gbc_video_memory_target.sv - self-checking bench for gbc_video_memory_target
module tb_gbc_video_memory_target;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ppu_mode;
  int         n_vec  = 0;
  int         n_fail = 0;

  gbc_video_memory_target_if bus();

  gbc_video_memory_target #(.VRAM_BANKS(2), .OAM_BYTES(160)) dut (
    .clk      (clk),
    .reset    (reset),
    .ppu_mode (ppu_mode),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  tga;
    logic        tgc;
    logic        we;
    logic [13:0] adr;
    logic [7:0]  dat;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  logic [7:0] vram_m [16384];
  logic [7:0] oam_m  [256];
  logic [7:0] reg_m  [64];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  function automatic bit locked(input logic [1:0] tga, input logic tgc, input logic [1:0] mode);
`ifdef GBC_VRAM_LOCKOUT_EN
    if (tgc) return 1'b0;
    if (tga == 2'b00) return mode == 2'd3;
    if (tga == 2'b01) return mode >= 2'd2;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_req(input logic [1:0] tga, input logic tgc, input logic we,
                        input logic [13:0] adr, input logic [7:0] dat, input logic [1:0] mode,
                        input logic [7:0] exp, input string name);
    @(negedge clk);
    chk({name, " stall"}, {7'b0, bus.wb_stall}, 8'h00);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_adr   = adr;
    bus.wb_dat_i = dat;
    bus.wb_tga   = tga;
    bus.wb_tgc   = tgc;
    ppu_mode     = mode;
    @(negedge clk);
    bus.wb_stb = 1'b0;
    if (tga == 2'b00 && tgc) begin
      chk({name, " copy stall"}, {7'b0, bus.wb_stall}, 8'h01);
      chk({name, " early ack"}, {7'b0, bus.wb_ack}, 8'h00);
      @(negedge clk);
    end
    chk({name, " ack"}, {7'b0, bus.wb_ack}, 8'h01);
    chk({name, " data"}, bus.wb_dat_o, exp);
    @(negedge clk);
    chk({name, " ack pulse"}, {7'b0, bus.wb_ack}, 8'h00);
    bus.wb_cyc = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        bb[8];
    logic [1:0]  tga, mode;
    logic        tgc, we;
    logic [13:0] adr;
    logic [7:0]  dat, exp, a8;
    logic [7:0]  lo;
    logic        bank;

    reset = 1'b1; ppu_mode = 2'd0;
    bus.wb_cyc = 0; bus.wb_stb = 0; bus.wb_we = 0; bus.wb_adr = '0;
    bus.wb_dat_i = '0; bus.wb_tga = '0; bus.wb_tgc = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset ack", {7'b0, bus.wb_ack}, 8'h00);
    chk("reset dat", bus.wb_dat_o, 8'h00);
    chk("reset stall", {7'b0, bus.wb_stall}, 8'h01);
    reset = 1'b0;
    chk("first cycle stall", {7'b0, bus.wb_stall}, 8'h01);

    // Directed single-request vectors
    tbl.push_back('{2'b00, 1'b0, 1'b1, 14'h0010, 8'h3C, 8'h3C, "vram wr lo"});
    tbl.push_back('{2'b00, 1'b0, 1'b1, 14'h2010, 8'h5A, 8'h5A, "vram wr bank1"});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 14'h2010, 8'h00, 8'h5A, "vram rd bank1"});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 14'h0010, 8'h00, 8'h3C, "vram rd lo"});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 14'h00A0, 8'h00, 8'h00, "oam rd oob"});
    tbl.push_back('{2'b01, 1'b0, 1'b1, 14'h00A0, 8'h77, 8'h00, "oam wr oob"});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 14'h00A0, 8'h00, 8'h00, "oam rd oob again"});
    tbl.push_back('{2'b01, 1'b0, 1'b1, 14'h009F, 8'h42, 8'h42, "oam wr last"});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 14'h009F, 8'h00, 8'h42, "oam rd last"});
    tbl.push_back('{2'b01, 1'b1, 1'b1, 14'h0020, 8'h6B, 8'hD0, "dma wr"});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 14'h0020, 8'h00, 8'h6B, "oam rd dma"});
    tbl.push_back('{2'b11, 1'b0, 1'b1, 14'h0123, 8'h55, 8'hFF, "rsvd wr"});
    tbl.push_back('{2'b11, 1'b0, 1'b0, 14'h0123, 8'h00, 8'hFF, "rsvd rd"});
    tbl.push_back('{2'b10, 1'b0, 1'b1, 14'h003F, 8'h9A, 8'h9A, "reg wr 3f"});
    tbl.push_back('{2'b10, 1'b0, 1'b0, 14'h003F, 8'h00, 8'h9A, "reg rd 3f"});
    foreach (tbl[i])
      do_req(tbl[i].tga, tbl[i].tgc, tbl[i].we, tbl[i].adr, tbl[i].dat, 2'd0, tbl[i].exp, tbl[i].name);

    // Back-to-back register writes then reads
    for (int k = 0; k < 4; k++) begin
      bb[k]   = '{2'b10, 1'b0, 1'b1, 14'(k), 8'((k + 1) * 8'h11), 8'((k + 1) * 8'h11), "b2b wr"};
      bb[k+4] = '{2'b10, 1'b0, 1'b0, 14'(k), 8'h00, 8'((k + 1) * 8'h11), "b2b rd"};
    end
    @(negedge clk);
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) begin
        chk({bb[k-1].name, " ack"}, {7'b0, bus.wb_ack}, 8'h01);
        chk({bb[k-1].name, " data"}, bus.wb_dat_o, bb[k-1].exp);
      end
      if (k < 8) begin
        chk("b2b stall", {7'b0, bus.wb_stall}, 8'h00);
        bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = bb[k].we; bus.wb_adr = bb[k].adr;
        bus.wb_dat_i = bb[k].dat; bus.wb_tga = bb[k].tga; bus.wb_tgc = 0;
      end else begin
        bus.wb_stb = 0;
      end
      @(negedge clk);
    end
    chk("b2b ack end", {7'b0, bus.wb_ack}, 8'h00);
    bus.wb_cyc = 0;

    // DMA copy VRAM -> OAM
    do_req(2'b00, 1'b0, 1'b1, 14'h0005, 8'hC3, 2'd0, 8'hC3, "copy preload");
    do_req(2'b00, 1'b1, 1'b0, 14'h0005, 8'h00, 2'd3, 8'hA0, "copy");
    do_req(2'b01, 1'b0, 1'b0, 14'h0005, 8'h00, 2'd0, 8'hC3, "copy result");

    // PPU mode 3 CPU VRAM access
    do_req(2'b00, 1'b0, 1'b1, 14'h0100, 8'h34, 2'd0, 8'h34, "mode0 wr");
`ifdef GBC_VRAM_LOCKOUT_EN
    do_req(2'b00, 1'b0, 1'b1, 14'h0100, 8'h12, 2'd3, 8'hFF, "locked wr");
    do_req(2'b00, 1'b0, 1'b0, 14'h0100, 8'h00, 2'd3, 8'hFF, "locked rd");
    do_req(2'b00, 1'b0, 1'b0, 14'h0100, 8'h00, 2'd0, 8'h34, "unlocked rd");
    do_req(2'b01, 1'b0, 1'b0, 14'h0005, 8'h00, 2'd2, 8'hFF, "oam locked rd");
`else
    do_req(2'b00, 1'b0, 1'b1, 14'h0100, 8'h12, 2'd3, 8'h12, "mode3 wr");
    do_req(2'b00, 1'b0, 1'b0, 14'h0100, 8'h00, 2'd3, 8'h12, "mode3 rd");
    do_req(2'b00, 1'b0, 1'b0, 14'h0100, 8'h00, 2'd0, 8'h12, "mode0 rd");
    do_req(2'b01, 1'b0, 1'b0, 14'h0005, 8'h00, 2'd2, 8'hC3, "oam mode2 rd");
`endif

    // Cycle dropped during a copy: no ack, copy still lands
    do_req(2'b00, 1'b0, 1'b1, 14'h000A, 8'h5E, 2'd0, 8'h5E, "drop preload");
    do_req(2'b01, 1'b0, 1'b1, 14'h000A, 8'h01, 2'd0, 8'h01, "drop old");
    @(negedge clk);
    bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = 0; bus.wb_adr = 14'h000A; bus.wb_tga = 2'b00; bus.wb_tgc = 1;
    @(negedge clk);
    chk("drop stall", {7'b0, bus.wb_stall}, 8'h01);
    bus.wb_cyc = 0; bus.wb_stb = 0;
    @(negedge clk);
    chk("drop ack", {7'b0, bus.wb_ack}, 8'h00);
    chk("drop idle stall", {7'b0, bus.wb_stall}, 8'h00);
    do_req(2'b01, 1'b0, 1'b0, 14'h000A, 8'h00, 2'd0, 8'h5E, "drop result");

    // Reset during a copy aborts it
    do_req(2'b00, 1'b0, 1'b1, 14'h0009, 8'h99, 2'd0, 8'h99, "rst preload");
    do_req(2'b01, 1'b0, 1'b1, 14'h0009, 8'h33, 2'd0, 8'h33, "rst old");
    @(negedge clk);
    bus.wb_cyc = 1; bus.wb_stb = 1; bus.wb_we = 0; bus.wb_adr = 14'h0009; bus.wb_tga = 2'b00; bus.wb_tgc = 1;
    @(negedge clk);
    chk("rst copy stall", {7'b0, bus.wb_stall}, 8'h01);
    reset = 1'b1; bus.wb_stb = 0;
    @(negedge clk);
    chk("rst ack", {7'b0, bus.wb_ack}, 8'h00);
    chk("rst stall", {7'b0, bus.wb_stall}, 8'h01);
    reset = 1'b0; bus.wb_cyc = 0;
    do_req(2'b01, 1'b0, 1'b0, 14'h0009, 8'h00, 2'd0, 8'h33, "rst oam kept");
    do_req(2'b10, 1'b0, 1'b0, 14'h0000, 8'h00, 2'd0, 8'h00, "rst reg cleared");
    do_req(2'b00, 1'b0, 1'b0, 14'h2010, 8'h00, 2'd0, 8'h5A, "rst vram kept");

    // Known contents for the randomized region
    for (int i = 0; i < 64; i++) reg_m[i] = 8'h00;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 16; i++) begin
        adr = 14'(b * 8192 + i);
        dat = 8'($urandom);
        vram_m[adr] = dat;
        do_req(2'b00, 1'b0, 1'b1, adr, dat, 2'd0, dat, "init vram");
      end
    for (int i = 0; i < 16; i++) begin
      dat = 8'($urandom);
      oam_m[i] = dat;
      do_req(2'b01, 1'b1, 1'b1, 14'(i), dat, 2'd0, 8'hD0, "init oam");
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      tga  = 2'($urandom_range(0, 3));
      tgc  = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      mode = 2'($urandom_range(0, 3));
      dat  = 8'($urandom);
      bank = 1'($urandom_range(0, 1));
      lo   = 8'($urandom_range(0, 15));
      case (tga)
        2'b00:   adr = 14'(bank * 8192 + lo);
        2'b01:   begin a8 = bank ? 8'(160 + lo) : lo; adr = {6'b0, a8}; end
        default: adr = 14'($urandom);
      endcase
      a8 = adr[7:0];
      if (tga == 2'b00 && tgc) begin
        if (a8 < 160) oam_m[a8] = vram_m[adr];
        exp = 8'hA0;
      end else if (tga == 2'b00) begin
        if (locked(tga, tgc, mode)) exp = 8'hFF;
        else if (we) begin vram_m[adr] = dat; exp = dat; end
        else exp = vram_m[adr];
      end else if (tga == 2'b01 && tgc) begin
        if (a8 < 160) oam_m[a8] = dat;
        exp = 8'hD0;
      end else if (tga == 2'b01) begin
        if (locked(tga, tgc, mode)) exp = 8'hFF;
        else if (a8 >= 160) exp = 8'h00;
        else if (we) begin oam_m[a8] = dat; exp = dat; end
        else exp = oam_m[a8];
      end else if (tga == 2'b10) begin
        if (we) begin reg_m[adr[5:0]] = dat; exp = dat; end
        else exp = reg_m[adr[5:0]];
      end else begin
        exp = 8'hFF;
      end
      do_req(tga, tgc, we, adr, dat, mode, exp, $sformatf("rand%0d t%0d c%0d w%0d a%04h", n, tga, tgc, we, adr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/gbc_video_memory_target.md
GBC_VIDEO_MEMORY_TARGET -- requirements
Module: gbc_video_memory_target

Interface
REQ-001 The block SHALL have parameter VRAM_BANKS, default 2, giving the number of 8 KiB VRAM banks, selected by wb_adr[13].
REQ-002 The block SHALL have parameter OAM_BYTES, default 160, giving the number of implemented OAM bytes.
REQ-003 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, reset: synchronous, active-high.
REQ-005 The block SHALL have port wb_cyc, input, 1, Wishbone cycle.
REQ-006 The block SHALL have port wb_stb, input, 1, Wishbone strobe.
REQ-007 The block SHALL have port wb_we, input, 1, write enable.
REQ-008 The block SHALL have port wb_adr, input, 14, byte address.
REQ-009 The block SHALL have port wb_dat_i, input, 8, write data.
REQ-010 The block SHALL have port wb_tga, input, 2, address space: 00 VRAM, 01 OAM, 10 registers, 11 reserved.
REQ-011 The block SHALL have port wb_tgc, input, 1, cycle class: 0 CPU, 1 OAM DMA.
REQ-012 The block SHALL have port ppu_mode, input, 2, current PPU mode (0 HBlank, 1 VBlank, 2 OAM scan, 3 draw).
REQ-013 The block SHALL have port wb_dat_o, output, 8, read data.
REQ-014 The block SHALL have port wb_ack, output, 1, response strobe.
REQ-015 The block SHALL have port wb_stall, output, 1, request not accepted this cycle.

Function
REQ-016 Accept: a request SHALL be accepted on a cycle where wb_cyc&wb_stb&!wb_stall.
REQ-017 State machine SHALL have states IDLE, RESP and DMA_COPY; IDLE->RESP on an accepted non-copy request, IDLE->DMA_COPY on an accepted request with tgc=1 and tga=00, DMA_COPY->RESP after one cycle, and RESP->IDLE or RESP->RESP (back-to-back) on the next cycle.
REQ-018 Latency: wb_ack SHALL pulse for exactly one cycle, 1 cycle after acceptance for normal requests and 2 cycles after acceptance for DMA copy.
REQ-019 wb_stall SHALL be 1 in DMA_COPY, while reset is high, and on the first cycle after reset; otherwise it SHALL be 0, so that one request per cycle is pipelined.
REQ-020 VRAM (tga=00, tgc=0) SHALL use byte address {wb_adr[13], wb_adr[12:0]}; a read SHALL return the stored byte and a write SHALL store wb_dat_i and return wb_dat_i.
REQ-021 OAM (tga=01) SHALL use index wb_adr[7:0]; an index >= OAM_BYTES SHALL read 8'h00 with the write ignored, and a CPU read SHALL return the stored byte.
REQ-022 DMA write (tga=01, tgc=1) SHALL store wb_dat_i into OAM[wb_adr[7:0]] and respond 8'hD0.
REQ-023 DMA copy (tga=00, tgc=1) SHALL read VRAM[wb_adr] in the accept cycle, write the byte to OAM[wb_adr[7:0]] in DMA_COPY, and respond 8'hA0.
REQ-024 Registers (tga=10) SHALL use a 64-byte file indexed by wb_adr[5:0]; a read SHALL return the stored byte and a write SHALL store the byte.
REQ-025 The reserved space (tga=11) SHALL be acknowledged with 8'hFF and writes ignored.
REQ-026 DMA cycles (tgc=1) SHALL ignore ppu_mode.
REQ-027 If wb_cyc falls while in RESP or DMA_COPY, the block SHALL suppress the pending ack, commit a DMA copy already in progress, and return to IDLE.
REQ-028 A simultaneous VRAM write and DMA copy read of the same byte SHALL not occur, because the copy stalls the bus.

Reset
REQ-029 On reset the block SHALL set the state to IDLE, wb_ack to 0, wb_dat_o to 8'h00, wb_stall to 1, and all register-file bytes to 8'h00.
REQ-030 Reset SHALL NOT clear VRAM or OAM contents.
REQ-031 Reset in DMA_COPY SHALL abort the copy and leave the OAM byte unwritten.

Configuration
REQ-032 When GBC_VRAM_LOCKOUT_EN is defined, a CPU VRAM access during ppu_mode=3 and a CPU OAM access during ppu_mode 2 or 3 SHALL read 8'hFF, drop the write, and still ack at normal latency.
REQ-033 When GBC_VRAM_LOCKOUT_EN is undefined, ppu_mode SHALL be ignored and all accesses SHALL proceed.

Verification
REQ-034 The bench SHALL write tga=00, adr=14'h2010, data 8'h5A, then read the same address -> ack 1 cycle after each accept, with the read returning 8'h5A and adr 14'h0010 unchanged.
REQ-035 The bench SHALL issue 4 back-to-back register writes adr 0..3 with data 8'h11..8'h44, then read them -> no stall, 4 consecutive acks, and reads 8'h11, 8'h22, 8'h33, 8'h44.
REQ-036 The bench SHALL preload VRAM[14'h0005]=8'hC3, then issue a DMA copy tga=00 tgc=1 adr=14'h0005 -> stall 1 cycle, ack at cycle 2 with 8'hA0, and an OAM read at index 5 returning 8'hC3.
REQ-037 The bench SHALL issue an OAM read at index 8'hA0, plus a write of 8'h77 there -> read 8'h00 and the write ignored.
REQ-038 With GBC_VRAM_LOCKOUT_EN defined and ppu_mode=3, the bench SHALL issue a CPU VRAM write of 8'h12 then a read -> 8'hFF, with the stored byte unchanged when read in mode 0.
REQ-039 The bench SHALL assert reset during DMA_COPY -> next cycle ack=0 and stall=1, and the target OAM byte retains its old value.
